period_meter_ctrl: RTL and testbench

Measurement sequencer for the frequency estimator. Enables the zero-crossing detector on `start`, discards its pipeline warm-up, times N_PER consecutive signal periods in clock cycles from the detector's `flag` pulses, and returns the accumulated cycle count through a valid/ready handshake. Sits between the detector and the downstream frequency-division stage.

---
 rtl/period_meter_ctrl_if.sv | 50 +++++
 rtl/period_meter_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_period_meter_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/period_meter_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : period_meter_ctrl_if
// Brief    : Control / result bundle between the period meter, its requester,
//            the zero-crossing detector and the frequency-division stage.
// Revision : 1.0 - initial release
// =============================================================================
interface period_meter_ctrl_if #(
    parameter int CNT_W = 24
);
    logic             start;
    logic             abort;
    logic             zc_flag;
    logic             result_ready;
    logic             zc_enable;
    logic             busy;
    logic             result_valid;
    logic [CNT_W-1:0] period_sum;
    logic             ovf;
    logic             timeout;

    // Environment side: requester, detector and result consumer.
    modport master (
        output start,
        output abort,
        output zc_flag,
        output result_ready,
        input  zc_enable,
        input  busy,
        input  result_valid,
        input  period_sum,
        input  ovf,
        input  timeout
    );

    // Meter side.
    modport slave (
        input  start,
        input  abort,
        input  zc_flag,
        input  result_ready,
        output zc_enable,
        output busy,
        output result_valid,
        output period_sum,
        output ovf,
        output timeout
    );
endinterface
`default_nettype wire

// File: rtl/period_meter_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : period_meter_ctrl
// Brief    : Times N_PER zero-crossing periods in clock cycles and hands the
//            accumulated count over a valid/ready handshake. Optional watchdog
//            enabled by defining PERIOD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module period_meter_ctrl #(
    parameter int CNT_W       = 24,
    parameter int N_PER       = 8,
    parameter int TIMEOUT_CYC = 1048576
) (
    input wire                 clk,
    input wire                 reset,
    period_meter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [1:0]       c_ARM_SKIP = 2'd2;
    localparam logic [7:0]       c_LAST_PER = 8'(N_PER - 1);
    localparam logic [CNT_W-1:0] c_CYC_MAX  = '1;

    generate
        if (N_PER < 1 || N_PER > 255) begin : g_bad_n_per
            $error("period_meter_ctrl: N_PER must lie in 1..255");
        end
        if (TIMEOUT_CYC < 1) begin : g_bad_timeout
            $error("period_meter_ctrl: TIMEOUT_CYC must be at least 1");
        end
    endgenerate

    state_t           r_state;
    state_t           w_state_nxt;

    logic [1:0]       r_skip_cnt;
    logic [7:0]       r_per_cnt;
    logic [CNT_W-1:0] r_cyc_cnt;
    logic             r_ovf_acc;

    logic             r_zc_enable;
    logic             r_busy;
    logic             r_result_valid;
    logic [CNT_W-1:0] r_period_sum;
    logic             r_ovf;

    logic [CNT_W-1:0] w_cyc_inc;
    logic             w_cyc_max;
    logic             w_in_window;
    logic             w_skip_done;
    logic             w_flag_acc;
    logic             w_last_flag;
    logic             w_arm_entry;
    logic             w_done_entry;
    logic             w_wd_hit;
    logic             w_wd_done;

    // Saturating cycle increment; the final sum reuses it so the completing
    // flag cycle is counted too.
    always_comb begin
        w_cyc_max = (r_cyc_cnt == c_CYC_MAX);
        w_cyc_inc = w_cyc_max ? r_cyc_cnt : (r_cyc_cnt + CNT_W'(1));
    end

    always_comb begin
        w_in_window = (r_state == S_ARM) || (r_state == S_MEASURE);
        w_skip_done = (r_skip_cnt == c_ARM_SKIP);
        w_flag_acc  = bus.zc_flag &&
                      (((r_state == S_ARM) && w_skip_done) || (r_state == S_MEASURE));
        w_last_flag = bus.zc_flag && (r_state == S_MEASURE) && (r_per_cnt == c_LAST_PER);
    end

    // Priority: abort over watchdog over flag/handshake.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.start)        w_state_nxt = S_ARM;
            S_ARM:     if (w_flag_acc)       w_state_nxt = S_MEASURE;
            S_MEASURE: if (w_last_flag)      w_state_nxt = S_DONE;
            S_DONE:    if (bus.result_ready) w_state_nxt = S_IDLE;
            default:                         w_state_nxt = S_IDLE;
        endcase
        if (w_in_window && w_wd_hit) begin
            w_state_nxt = S_DONE;
        end
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        w_arm_entry  = (r_state == S_IDLE) && (w_state_nxt == S_ARM);
        w_done_entry = (r_state != S_DONE) && (w_state_nxt == S_DONE);
        w_wd_done    = w_in_window && w_wd_hit && !bus.abort;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Status outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zc_enable    <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_zc_enable    <= (w_state_nxt == S_ARM) || (w_state_nxt == S_MEASURE);
            r_busy         <= (w_state_nxt == S_ARM) || (w_state_nxt == S_MEASURE);
            r_result_valid <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_skip_cnt <= 2'd0;
            r_per_cnt  <= 8'd0;
            r_cyc_cnt  <= '0;
            r_ovf_acc  <= 1'b0;
        end else if (w_arm_entry) begin
            r_skip_cnt <= 2'd0;
            r_per_cnt  <= 8'd0;
            r_ovf_acc  <= 1'b0;
        end else if (r_state == S_ARM) begin
            // Detector history is stale right after enable; skip its first flags.
            if (!w_skip_done) begin
                r_skip_cnt <= r_skip_cnt + 2'd1;
            end
            r_cyc_cnt <= '0;
        end else if (r_state == S_MEASURE) begin
            r_cyc_cnt <= w_cyc_inc;
            if (w_cyc_max) begin
                r_ovf_acc <= 1'b1;
            end
            if (bus.zc_flag) begin
                r_per_cnt <= r_per_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period_sum <= '0;
            r_ovf        <= 1'b0;
        end else if (w_done_entry) begin
            if (w_wd_done) begin
                r_period_sum <= '0;
                r_ovf        <= r_ovf_acc;
            end else begin
                r_period_sum <= w_cyc_inc;
                r_ovf        <= r_ovf_acc | w_cyc_max;
            end
        end
    end

`ifdef PERIOD_TIMEOUT_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYC - 1);

    logic [c_WD_W-1:0] r_wd_cnt;
    logic              r_timeout;

    // Counts every ARM/MEASURE cycle since the last accepted flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if (w_arm_entry || w_flag_acc || !w_in_window) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
        end
    end

    assign w_wd_hit = (r_wd_cnt == c_WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if (w_done_entry) begin
            r_timeout <= w_wd_done;
        end
    end

    assign bus.timeout = r_timeout;
`else
    assign w_wd_hit    = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.zc_enable    = r_zc_enable;
    assign bus.busy         = r_busy;
    assign bus.result_valid = r_result_valid;
    assign bus.period_sum   = r_period_sum;
    assign bus.ovf          = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_period_meter_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_period_meter_ctrl
// Brief    : Directed self-checking bench for period_meter_ctrl.
// Revision : 1.0 - initial release
// =============================================================================
module tb_period_meter_ctrl;

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic start_c = 1'b0;
    logic zc      = 1'b0;
    logic abort   = 1'b0;
    logic ready   = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int dc;

    always #5 clk = ~clk;

    period_meter_ctrl_if #(.CNT_W(24)) bus_a ();
    period_meter_ctrl_if #(.CNT_W(8))  bus_b ();
    period_meter_ctrl_if #(.CNT_W(24)) bus_c ();

    assign bus_a.start = start_a;
    assign bus_b.start = start_b;
    assign bus_c.start = start_c;
    assign bus_a.zc_flag = zc;
    assign bus_b.zc_flag = zc;
    assign bus_c.zc_flag = zc;
    assign bus_a.abort = abort;
    assign bus_b.abort = abort;
    assign bus_c.abort = abort;
    assign bus_a.result_ready = ready;
    assign bus_b.result_ready = ready;
    assign bus_c.result_ready = ready;

    period_meter_ctrl #(.CNT_W(24), .N_PER(8), .TIMEOUT_CYC(1048576)) u_dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    period_meter_ctrl #(.CNT_W(8), .N_PER(4), .TIMEOUT_CYC(1048576)) u_dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));
    period_meter_ctrl #(.CNT_W(24), .N_PER(8), .TIMEOUT_CYC(64)) u_dut_c (
        .clk(clk), .reset(reset), .bus(bus_c));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic valid_of(input int sel);
        case (sel)
            0:       return bus_a.result_valid;
            1:       return bus_b.result_valid;
            default: return bus_c.result_valid;
        endcase
    endfunction

    task automatic pulse_start(input int sel);
        case (sel)
            0:       start_a = 1'b1;
            1:       start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    // Flags at cycle first_gap and every period after; returns the loop index
    // at which result_valid was first seen, or -1 if the budget ran out.
    task automatic run_flags(input int sel, input int first_gap, input int period,
                             input int max_cyc, output int done_c);
        done_c = -1;
        for (int c = 0; c < max_cyc; c++) begin
            zc = (c >= first_gap) && (((c - first_gap) % period) == 0);
            tick();
            if (valid_of(sel)) begin
                done_c = c;
                break;
            end
        end
        zc = 1'b0;
    endtask

    task automatic handshake(input int sel, input string tag);
        ready = 1'b1;
        tick();
        check(tag, 32'(valid_of(sel)), 32'd0);
        ready = 1'b0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        #1 reset = 1'b1;
        tick();
        tick();
        check("rst_zc_enable", 32'(bus_a.zc_enable), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_valid", 32'(bus_a.result_valid), 32'd0);
        check("rst_sum", 32'(bus_a.period_sum), 32'd0);
        check("rst_ovf", 32'(bus_a.ovf), 32'd0);
        check("rst_timeout", 32'(bus_a.timeout), 32'd0);
        @(negedge clk) reset = 1'b0;
        tick();

        // 8 periods of 100 cycles; reference flag at loop index 5
        pulse_start(0);
        check("arm_zc_enable", 32'(bus_a.zc_enable), 32'd1);
        check("arm_busy", 32'(bus_a.busy), 32'd1);
        run_flags(0, 5, 100, 2000, dc);
        check("p100_done_cycle", 32'(dc), 32'd805);
        check("p100_sum", 32'(bus_a.period_sum), 32'd800);
        check("p100_ovf", 32'(bus_a.ovf), 32'd0);
        check("p100_timeout", 32'(bus_a.timeout), 32'd0);
        check("p100_busy", 32'(bus_a.busy), 32'd0);

        // Consumer stalls 20 cycles while start is pulsed
        for (int i = 0; i < 20; i++) begin
            start_a = (i == 7);
            tick();
        end
        start_a = 1'b0;
        check("stall_valid", 32'(bus_a.result_valid), 32'd1);
        check("stall_sum", 32'(bus_a.period_sum), 32'd800);
        check("stall_busy", 32'(bus_a.busy), 32'd0);
        ready   = 1'b1;
        start_a = 1'b1;
        tick();
        check("hs_valid", 32'(bus_a.result_valid), 32'd0);
        check("hs_start_ignored", 32'(bus_a.busy), 32'd0);
        ready   = 1'b0;
        start_a = 1'b0;
        tick();
        check("idle_busy", 32'(bus_a.busy), 32'd0);
        check("idle_zc_enable", 32'(bus_a.zc_enable), 32'd0);

        // Flag in the first ARM cycle must be skipped
        pulse_start(0);
        run_flags(0, 0, 50, 2000, dc);
        check("skip_done_cycle", 32'(dc), 32'd450);
        check("skip_sum", 32'(bus_a.period_sum), 32'd400);
        check("skip_ovf", 32'(bus_a.ovf), 32'd0);
        handshake(0, "skip_hs_valid");

        // Narrow accumulator saturates: 4 x 100 > 255
        pulse_start(1);
        run_flags(1, 5, 100, 2000, dc);
        check("sat_done_cycle", 32'(dc), 32'd405);
        check("sat_sum", 32'(bus_b.period_sum), 32'd255);
        check("sat_ovf", 32'(bus_b.ovf), 32'd1);
        handshake(1, "sat_hs_valid");

        // Abort in the 37th MEASURE cycle
        pulse_start(0);
        for (int c = 0; c < 42; c++) begin
            zc = (c == 5);
            tick();
        end
        zc = 1'b0;
        check("pre_abort_busy", 32'(bus_a.busy), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_zc_enable", 32'(bus_a.zc_enable), 32'd0);
        check("abort_busy", 32'(bus_a.busy), 32'd0);
        check("abort_valid", 32'(bus_a.result_valid), 32'd0);
        run_flags(0, 0, 100, 300, dc);
        check("abort_no_result", 32'(dc), 32'hFFFF_FFFF);

        // abort wins over start in IDLE
        start_a = 1'b1;
        abort   = 1'b1;
        tick();
        start_a = 1'b0;
        abort   = 1'b0;
        check("abort_start_busy", 32'(bus_a.busy), 32'd0);
        tick();

        // Asynchronous reset in the middle of ARM
        pulse_start(0);
        tick();
        check("arm2_zc_enable", 32'(bus_a.zc_enable), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("async_zc_enable", 32'(bus_a.zc_enable), 32'd0);
        check("async_busy", 32'(bus_a.busy), 32'd0);
        check("async_sum", 32'(bus_a.period_sum), 32'd0);
        @(negedge clk) reset = 1'b0;
        tick();

        // No flags at all: watchdog (if built) fires after 64 ARM cycles
        pulse_start(2);
`ifdef PERIOD_TIMEOUT_EN
        repeat (63) tick();
        check("wd_early_valid", 32'(bus_c.result_valid), 32'd0);
        tick();
        check("wd_valid", 32'(bus_c.result_valid), 32'd1);
        check("wd_timeout", 32'(bus_c.timeout), 32'd1);
        check("wd_sum", 32'(bus_c.period_sum), 32'd0);
        handshake(2, "wd_hs_valid");
`else
        repeat (1000) tick();
        check("nowd_busy", 32'(bus_c.busy), 32'd1);
        check("nowd_valid", 32'(bus_c.result_valid), 32'd0);
        check("nowd_timeout", 32'(bus_c.timeout), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("nowd_abort_busy", 32'(bus_c.busy), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
